// File: rtl/tx_message_scheduler_if.sv
// Bundles the request side (game-state logic) and the link side (sender/receiver) of the scheduler.
// No timing of its own; it only carries signals between the blocks.
// Backpressure reaches the requester only through busy; the sender throttles with message_sent.
interface tx_message_scheduler_if;
    // requests and payloads from the game-state logic
    logic       ball_req;
    logic [8:0] ball_y_in;
    logic [3:0] velocity_x_in;
    logic [3:0] velocity_y_in;
    logic       miss_req;
    logic [4:0] my_score_in;
    logic [4:0] your_score_in;
    logic       you_should_serve_in;
    logic       new_game_req;
    logic       you_serve_first_in;
    logic       new_game_ack_req;
    // receiver status
    logic       new_message_received;
    logic       new_game_ack_message_rx;
    // sender handshake and registered message
    logic       message_sent;
    logic       send_new_message;
    logic       ball_message_tx;
    logic       miss_message_tx;
    logic       new_game_message_tx;
    logic       new_game_ack_message_tx;
    logic [8:0] ball_y_tx;
    logic [3:0] velocity_x_tx;
    logic [3:0] velocity_y_tx;
    logic [4:0] my_score_tx;
    logic [4:0] your_score_tx;
    logic       you_should_serve_tx;
    logic       you_serve_first_tx;
    // status
    logic       busy;
    logic       new_game_done;
    logic       link_fail;

    modport master (
        output ball_req, ball_y_in, velocity_x_in, velocity_y_in,
               miss_req, my_score_in, your_score_in, you_should_serve_in,
               new_game_req, you_serve_first_in, new_game_ack_req,
               new_message_received, new_game_ack_message_rx, message_sent,
        input  send_new_message, ball_message_tx, miss_message_tx,
               new_game_message_tx, new_game_ack_message_tx,
               ball_y_tx, velocity_x_tx, velocity_y_tx, my_score_tx, your_score_tx,
               you_should_serve_tx, you_serve_first_tx,
               busy, new_game_done, link_fail
    );

    modport slave (
        input  ball_req, ball_y_in, velocity_x_in, velocity_y_in,
               miss_req, my_score_in, your_score_in, you_should_serve_in,
               new_game_req, you_serve_first_in, new_game_ack_req,
               new_message_received, new_game_ack_message_rx, message_sent,
        output send_new_message, ball_message_tx, miss_message_tx,
               new_game_message_tx, new_game_ack_message_tx,
               ball_y_tx, velocity_x_tx, velocity_y_tx, my_score_tx, your_score_tx,
               you_should_serve_tx, you_serve_first_tx,
               busy, new_game_done, link_fail
    );
endinterface

// File: rtl/tx_message_scheduler.sv
// Queues one pending message per type and hands them to the sender one at a time by fixed priority.
// Latency: a request edge sets its pending bit; the next idle edge loads it, so send_new_message rises one cycle later.
// Backpressure: a message is held until message_sent; ball/miss stay queued while a new-game ack is outstanding.
module tx_message_scheduler #(
    parameter int RETRY_CYCLES = 50000000,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                  clock,
    input  logic                  reset_L,
    tx_message_scheduler_if.slave bus
);
    localparam int TW = $clog2(RETRY_CYCLES + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int P_BALL = 0;
    localparam int P_MISS = 1;
    localparam int P_NG   = 2;
    localparam int P_ACK  = 3;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [3:0]    pending, eligible, grant;
    logic          load;
    // stored payload per slot; the ack message carries no payload
    logic [8:0]    ball_y_q;
    logic [3:0]    vx_q, vy_q;
    logic [4:0]    my_q, your_q;
    logic          serve_q, first_q;
    // new-game ack tracking
    logic          awaiting, ng_retry, ack_prev;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic          ack_now, ack_rise, ng_accept, ack_hit;
    logic          timeout, retry_post, give_up;

    assign ack_now    = bus.new_message_received & bus.new_game_ack_message_rx;
    assign ack_rise   = ack_now & ~ack_prev;
    assign ng_accept  = load & grant[P_NG];
    // an accept on the same edge re-arms the wait, so the ack is taken as stale
    assign ack_hit    = ack_rise & awaiting & ~ng_accept;
    assign timeout    = awaiting && (state == IDLE) && (timer == TW'(RETRY_CYCLES - 1));
    assign retry_post = timeout && (retries <  RW'(MAX_RETRIES));
    assign give_up    = timeout && (retries >= RW'(MAX_RETRIES));
    assign bus.busy   = (|pending) | (state == SEND) | awaiting;

    // State register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // Priority pick among unblocked slots and next-state decision
    always_comb begin
        eligible  = pending & (awaiting ? 4'b1100 : 4'b1111);
        grant     = 4'b0000;
        load      = 1'b0;
        state_nxt = state;
        if      (eligible[P_ACK])  grant[P_ACK]  = 1'b1;
        else if (eligible[P_NG])   grant[P_NG]   = 1'b1;
        else if (eligible[P_MISS]) grant[P_MISS] = 1'b1;
        else if (eligible[P_BALL]) grant[P_BALL] = 1'b1;
        case (state)
            IDLE: if (|eligible) begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (bus.message_sent) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pending bits and slot payloads; a same-edge request re-arms the slot it just vacated
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            pending  <= '0;
            ball_y_q <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            my_q     <= '0;
            your_q   <= '0;
            serve_q  <= 1'b0;
            first_q  <= 1'b0;
            ng_retry <= 1'b0;
        end else begin
            pending <= (pending & ~(load ? grant : 4'b0000)) |
                       {bus.new_game_ack_req, bus.new_game_req | retry_post, bus.miss_req, bus.ball_req};
            if (bus.ball_req) begin
                ball_y_q <= bus.ball_y_in;
                vx_q     <= bus.velocity_x_in;
                vy_q     <= bus.velocity_y_in;
            end
            if (bus.miss_req) begin
                my_q    <= bus.my_score_in;
                your_q  <= bus.your_score_in;
                serve_q <= bus.you_should_serve_in;
            end
            if (bus.new_game_req) first_q <= bus.you_serve_first_in;
            // remembers whether the queued new-game is a resend, so its accept keeps the retry count
            if (bus.new_game_req)    ng_retry <= 1'b0;
            else if (retry_post)     ng_retry <= 1'b1;
        end
    end

    // Ack wait, retry timer/count, link failure and completion pulse
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            awaiting          <= 1'b0;
            timer             <= '0;
            retries           <= '0;
            ack_prev          <= 1'b0;
            bus.link_fail     <= 1'b0;
            bus.new_game_done <= 1'b0;
        end else begin
            ack_prev          <= ack_now;
            bus.new_game_done <= ack_hit;
            if (ng_accept)                 awaiting <= 1'b1;
            else if (ack_hit || give_up)   awaiting <= 1'b0;
            if (ng_accept || timeout || !awaiting) timer <= '0;
            else if (state == IDLE)                timer <= timer + 1'b1;
            if (ng_accept && !ng_retry) retries <= '0;
            else if (retry_post)        retries <= retries + 1'b1;
            if (ack_hit)      bus.link_fail <= 1'b0;
            else if (give_up) bus.link_fail <= 1'b1;
        end
    end

    // Output message registers: loaded on accept, held through SEND, cleared on message_sent
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            bus.send_new_message        <= 1'b0;
            bus.ball_message_tx         <= 1'b0;
            bus.miss_message_tx         <= 1'b0;
            bus.new_game_message_tx     <= 1'b0;
            bus.new_game_ack_message_tx <= 1'b0;
            bus.ball_y_tx               <= '0;
            bus.velocity_x_tx           <= '0;
            bus.velocity_y_tx           <= '0;
            bus.my_score_tx             <= '0;
            bus.your_score_tx           <= '0;
            bus.you_should_serve_tx     <= 1'b0;
            bus.you_serve_first_tx      <= 1'b0;
        end else if (load) begin
            bus.send_new_message        <= 1'b1;
            bus.ball_message_tx         <= grant[P_BALL];
            bus.miss_message_tx         <= grant[P_MISS];
            bus.new_game_message_tx     <= grant[P_NG];
            bus.new_game_ack_message_tx <= grant[P_ACK];
            bus.ball_y_tx               <= grant[P_BALL] ? ball_y_q : 9'd0;
            bus.velocity_x_tx           <= grant[P_BALL] ? vx_q : 4'd0;
            bus.velocity_y_tx           <= grant[P_BALL] ? vy_q : 4'd0;
            bus.my_score_tx             <= grant[P_MISS] ? my_q : 5'd0;
            bus.your_score_tx           <= grant[P_MISS] ? your_q : 5'd0;
            bus.you_should_serve_tx     <= grant[P_MISS] & serve_q;
            bus.you_serve_first_tx      <= grant[P_NG] & first_q;
        end else if (state == SEND && bus.message_sent) begin
            bus.send_new_message        <= 1'b0;
            bus.ball_message_tx         <= 1'b0;
            bus.miss_message_tx         <= 1'b0;
            bus.new_game_message_tx     <= 1'b0;
            bus.new_game_ack_message_tx <= 1'b0;
            bus.ball_y_tx               <= '0;
            bus.velocity_x_tx           <= '0;
            bus.velocity_y_tx           <= '0;
            bus.my_score_tx             <= '0;
            bus.your_score_tx           <= '0;
            bus.you_should_serve_tx     <= 1'b0;
            bus.you_serve_first_tx      <= 1'b0;
        end
    end
endmodule

// File: doc/tx_message_scheduler.md
Name: tx_message_scheduler

Overview:
Sequences all outgoing link traffic into CommunicationSender: one message at a time over the send_new_message/message_sent handshake. Game-state logic posts single-cycle requests for ball, miss, new-game and new-game-ack messages. The block queues one pending slot per type, arbitrates by fixed priority, holds the payload stable for the whole handshake, and retries new-game messages until the peer acknowledges. It sits between gameStateModule and CommunicationSender in ChipInterface.

Parameters:
RETRY_CYCLES, 50000000, clock cycles to wait for a new-game ack before resending (1 s at 50 MHz).
MAX_RETRIES, 3, number of resends allowed before declaring link failure.

Ports:
clock  in  1  system clock, CLOCK_50
reset_L  in  1  asynchronous active-low reset
ball_req  in  1  pulse: post ball message; payload below sampled on same edge
ball_y_in  in  9  ball row
velocity_x_in  in  4  x speed, unsigned
velocity_y_in  in  4  y speed, signed
miss_req  in  1  pulse: post miss message
my_score_in  in  5  local score
your_score_in  in  5  remote score
you_should_serve_in  in  1  serve flag
new_game_req  in  1  pulse: post new-game message
you_serve_first_in  in  1  serve-first flag
new_game_ack_req  in  1  pulse: post new-game ack
new_message_received  in  1  from CommunicationReceiver
new_game_ack_message_rx  in  1  from CommunicationReceiver
message_sent  in  1  from CommunicationSender: current message accepted
send_new_message  out  1  to CommunicationSender
ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx  out  1 each  one-hot type
ball_y_tx  out  9;  velocity_x_tx, velocity_y_tx  out  4;  my_score_tx, your_score_tx  out  5;  you_should_serve_tx, you_serve_first_tx  out  1  registered payload
busy  out  1  high when any pending bit set, send active or awaiting ack
new_game_done  out  1  one-cycle pulse: peer acked new game
link_fail  out  1  sticky: retries exhausted

Behaviour:
- Reset (async, reset_L=0): every output 0, all pending bits 0, awaiting_ack 0, counters 0, state IDLE.
- Pending slot per type: req pulse sets pending bit, overwrites that slot's payload (latest wins). Request on the edge where the same type is accepted: bit stays set with new payload.
- FSM: IDLE, SEND.
- IDLE: if any pending and not blocked, pick highest priority: new_game_ack > new_game > miss > ball. Load its payload and one-hot type into the output registers, clear that pending bit, go to SEND. send_new_message rises on the next cycle. Request at edge N gives send_new_message high in cycle N+1 at the earliest.
- Blocking: while awaiting_ack=1, ball and miss stay pending, not sent. new_game_ack and new_game retries are still sent, so two resetting boards cannot deadlock.
- SEND: send_new_message, type and payload held constant. On an edge with message_sent=1, deassert all of them (type/payload fields to 0) and return to IDLE. Minimum one IDLE cycle between messages. message_sent while IDLE is ignored.
- New-game accept: at the edge where a new_game message is accepted, set awaiting_ack=1 and clear the retry timer. If it came from new_game_req rather than a timeout, also clear the retry count.
- Ack detect: rising edge of (new_message_received & new_game_ack_message_rx) while awaiting_ack=1. Clear awaiting_ack, pulse new_game_done for 1 cycle, clear link_fail. Acks while not awaiting are ignored.
- Timeout: timer counts while awaiting_ack and state IDLE. At RETRY_CYCLES-1:
  - retries<MAX_RETRIES: set new_game pending with the stored payload, retries+1, awaiting_ack stays 1.
  - retries==MAX_RETRIES: clear awaiting_ack, set link_fail (sticky until ack or reset). Blocked traffic then resumes.
- new_game_req while awaiting: re-posts, restarts the sequence with retries=0.
- Simultaneous requests of all types in one cycle: sent in priority order over four handshakes.
- reset_L low mid-SEND: send_new_message drops asynchronously and all pending traffic is discarded.

Test Plan:
- Reset then ball_req with ball_y_in=9'd200, vx=3, vy=-2 -> next cycle send_new_message=1, ball_message_tx=1, ball_y_tx=200, velocity_y_tx=4'hE; held until message_sent; deasserted the cycle after.
- Same-cycle ball_req, miss_req (scores 3/5), new_game_ack_req -> sends in order: ack, miss, ball. Each is a separate handshake with ≥1 idle cycle between.
- RETRY_CYCLES=20, MAX_RETRIES=2, new_game_req, no ack -> new_game sent 3 times, about 20 cycles apart. Then link_fail=1 and busy=0. A ball_req posted during the wait is sent only after link_fail.
- new_game sent, ack rx asserted 5 cycles later and held 4 cycles -> one new_game_done pulse, no resend, pending ball sent next.
- ball_req twice while the first ball is in SEND (ball_y_in 10 then 20) -> first handshake payload unchanged; second message carries 20; only two ball messages total.
- reset_L asserted mid-SEND with miss pending -> outputs 0 immediately; after release, no message is sent without a new request.
